// File: rtl/matrix_tx_ctrl_pkg.sv
// Shared definitions for the matrix transmit sequencer: state encoding and
// width helpers for the matrix read address and cell index.
package matrix_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SEND,
    ST_ACK,
    ST_DRAIN,
    ST_GAP,
    ST_DONE
  } state_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_width(input int rows);
    return idx_width(rows);
  endfunction

  function automatic int col_width(input int cols);
    return idx_width(cols);
  endfunction

  function automatic int cell_width(input int rows, input int cols);
    return idx_width(rows * cols);
  endfunction

endpackage

// File: rtl/matrix_tx_ctrl_if.sv
// Matrix read port plus transmitter start/data/busy handshake.
interface matrix_tx_ctrl_if #(
  parameter int W    = 8,
  parameter int ROWS = 2,
  parameter int COLS = 4
);
  localparam int RW = matrix_tx_ctrl_pkg::row_width(ROWS);
  localparam int CW = matrix_tx_ctrl_pkg::col_width(COLS);

  logic          rd_en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  tx_data;
  logic          tx_start;
  logic          tx_busy;

  // Sequencer side
  modport master (
    output rd_en, rd_row, rd_col, tx_data, tx_start,
    input  rd_data, tx_busy
  );

  // Matrix storage / transmitter side
  modport slave (
    input  rd_en, rd_row, rd_col, tx_data, tx_start,
    output rd_data, tx_busy
  );
endinterface

// File: rtl/matrix_tx_ctrl_gap_timer.sv
// Load/count-down timer shared by the inter-byte gap and the ack timeout.
// Load wins over decrement; the count parks at zero.
module matrix_tx_ctrl_gap_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [TW-1:0] count_reg;

  // Count register: reload on request, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - TW'(1);
    end
  end

  assign zero = (count_reg == '0);
endmodule

// File: rtl/matrix_tx_ctrl.sv
// Streams the ROWS x COLS cell matrix, row-major, through the UART
// transmitter on one start command, and locks out host writes meanwhile.
module matrix_tx_ctrl
  import matrix_tx_ctrl_pkg::*;
#(
  parameter int W      = 8,
  parameter int ROWS   = 2,
  parameter int COLS   = 4,
  parameter int GAP    = 2,
  parameter int ACK_TO = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                host_wr_req,
  output logic                                host_wr_gnt,
  matrix_tx_ctrl_if.master                    bus,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [cell_width(ROWS, COLS)-1:0]   cell_idx
);
  localparam int RW   = row_width(ROWS);
  localparam int CW   = col_width(COLS);
  localparam int IW   = cell_width(ROWS, COLS);
  localparam int TMAX = (GAP > ACK_TO) ? GAP : ACK_TO;
  localparam int TW   = idx_width(TMAX + 1);

  // Timer loads are one less than the wait length: the loaded cycle counts.
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TO - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS * COLS - 1);

  state_t        state_reg;
  logic [IW-1:0] cell_idx_reg;
  logic [W-1:0]  tx_data_reg;
  logic          err_reg;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_dec;
  logic          timer_zero;
  logic          last_cell;

  assign last_cell = (cell_idx_reg == LAST_IDX);
  assign timer_dec = (state_reg == ST_ACK) || (state_reg == ST_GAP);

  // Arm the timer on the edge that enters ACK or GAP.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (!abort && (state_reg == ST_SEND) && !bus.tx_busy) begin
      timer_load = 1'b1;
      timer_val  = ACK_LOAD;
    end else if (!abort && (state_reg == ST_DRAIN) && !bus.tx_busy && !last_cell) begin
      timer_load = 1'b1;
      timer_val  = GAP_LOAD;
    end
  end

  matrix_tx_ctrl_gap_timer #(.TW(TW)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Transfer sequencer: read cell, latch byte, hand to transmitter, wait out
  // the byte, then advance; abort or reset drop everything without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cell_idx_reg <= '0;
      tx_data_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if ((state_reg != ST_IDLE) && abort) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start && !abort) begin
              state_reg    <= ST_READ;
              cell_idx_reg <= '0;
            end
          end
          ST_READ:  state_reg <= ST_LATCH;
          ST_LATCH: begin
            tx_data_reg <= bus.rd_data;
            state_reg   <= ST_SEND;
          end
          ST_SEND: begin
            if (!bus.tx_busy) state_reg <= ST_ACK;
          end
          ST_ACK: begin
            if (bus.tx_busy) begin
              state_reg <= ST_DRAIN;
            end else if (timer_zero) begin
              err_reg   <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end
          ST_DRAIN: begin
            if (!bus.tx_busy) begin
              if (last_cell) begin
                state_reg <= ST_DONE;
              end else begin
                cell_idx_reg <= cell_idx_reg + IW'(1);
                if (GAP == 0) state_reg <= ST_READ;
                else          state_reg <= ST_GAP;
              end
            end
          end
          ST_GAP: begin
            if (timer_zero) state_reg <= ST_READ;
          end
          ST_DONE:  state_reg <= ST_IDLE;
          default:  state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign done         = (state_reg == ST_DONE);
  assign err          = err_reg;
  assign cell_idx     = cell_idx_reg;
  assign host_wr_gnt  = host_wr_req && (state_reg == ST_IDLE);
  assign bus.rd_en    = (state_reg == ST_READ);
  assign bus.rd_row   = RW'(int'(cell_idx_reg) / COLS);
  assign bus.rd_col   = CW'(int'(cell_idx_reg) % COLS);
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_start = (state_reg == ST_SEND) && !bus.tx_busy;
endmodule

// File: tb/tb_matrix_tx_ctrl.sv
// Bench for matrix_tx_ctrl: behavioural matrix storage and UART transmitter,
// scoreboard of expected read addresses and bytes, scenario tasks.
module tb_matrix_tx_ctrl;
  import matrix_tx_ctrl_pkg::*;

  localparam int W      = 8;
  localparam int ROWS   = 2;
  localparam int COLS   = 4;
  localparam int GAP    = 2;
  localparam int ACK_TO = 4;
  localparam int N      = ROWS * COLS;
  localparam int TXLEN  = 20;
  localparam int RW     = row_width(ROWS);
  localparam int CW     = col_width(COLS);
  localparam int IW     = cell_width(ROWS, COLS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic host_wr_req = 1'b0;
  logic host_wr_gnt, busy, done, err;
  logic [IW-1:0] cell_idx;

  matrix_tx_ctrl_if #(.W(W), .ROWS(ROWS), .COLS(COLS)) bus ();

  matrix_tx_ctrl #(.W(W), .ROWS(ROWS), .COLS(COLS), .GAP(GAP), .ACK_TO(ACK_TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .host_wr_req (host_wr_req),
    .host_wr_gnt (host_wr_gnt),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cell_idx    (cell_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Matrix storage: host write port and registered read port.
  logic [W-1:0] mem [N];
  logic [W-1:0] exp_mem [N];
  int           wr_addr = 0;
  logic [W-1:0] wr_val = '0;
  always @(posedge clk) begin
    if (host_wr_req && host_wr_gnt) mem[wr_addr] <= wr_val;
    if (bus.rd_en) bus.rd_data <= mem[int'(bus.rd_row) * COLS + int'(bus.rd_col)];
  end

  // Transmitter: busy for TXLEN clocks after an accepted start.
  logic force_busy = 1'b0;
  logic tx_mute = 1'b0;
  int   tx_cnt = 0;
  always @(posedge clk) begin
    if (bus.tx_start && !tx_mute) tx_cnt <= TXLEN;
    else if (tx_cnt != 0)         tx_cnt <= tx_cnt - 1;
  end
  assign bus.tx_busy = force_busy | (tx_cnt != 0);

  // Scoreboard and statistics
  int           exp_addr [$];
  logic [W-1:0] exp_byte [$];
  int n_checks = 0;
  int n_pass = 0;
  int epoch = 0;
  int mon_epoch = 0;
  int n_tx = 0, n_done = 0, n_err = 0, n_gnt_busy = 0;
  int first_rd_cyc = -1, first_tx_cyc = -1, last_tx_cyc = -1, err_cyc = -1;
  int mon_a;
  logic [W-1:0] mon_b;

  // Monitor: compare each read address and transmitted byte as it appears.
  always @(negedge clk) begin
    if (mon_epoch != epoch) begin
      mon_epoch = epoch;
      n_tx = 0; n_done = 0; n_err = 0; n_gnt_busy = 0;
      first_rd_cyc = -1; first_tx_cyc = -1; last_tx_cyc = -1; err_cyc = -1;
    end
    if (!rst) begin
      if (bus.rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        n_checks++;
        if (exp_addr.size() == 0) begin
          $display("FAIL rd_addr: got read row=%0d col=%0d at cycle %0d, expected no read",
                   bus.rd_row, bus.rd_col, cyc);
        end else begin
          mon_a = exp_addr.pop_front();
          if (bus.rd_row !== RW'(mon_a / COLS) || bus.rd_col !== CW'(mon_a % COLS))
            $display("FAIL rd_addr: got (%0d,%0d) expected (%0d,%0d)",
                     bus.rd_row, bus.rd_col, mon_a / COLS, mon_a % COLS);
          else n_pass++;
        end
      end
      if (bus.tx_start) begin
        n_tx++;
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        n_checks++;
        if (exp_byte.size() == 0) begin
          $display("FAIL tx_byte: got tx_start data=%0h at cycle %0d, expected no start",
                   bus.tx_data, cyc);
        end else begin
          mon_b = exp_byte.pop_front();
          if (bus.tx_data !== mon_b)
            $display("FAIL tx_byte: got %0h expected %0h", bus.tx_data, mon_b);
          else n_pass++;
        end
        if (last_tx_cyc >= 0) begin
          n_checks++;
          if (cyc - last_tx_cyc < TXLEN + GAP)
            $display("FAIL tx_spacing: got %0d clocks expected >= %0d", cyc - last_tx_cyc, TXLEN + GAP);
          else n_pass++;
        end
        last_tx_cyc = cyc;
      end
      if (done) n_done++;
      if (err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (busy && host_wr_gnt) n_gnt_busy++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_cell(input int a, input logic [W-1:0] v);
    @(negedge clk);
    host_wr_req = 1'b1; wr_addr = a; wr_val = v;
    @(negedge clk);
    host_wr_req = 1'b0;
    exp_mem[a] = v;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(i);
      exp_byte.push_back(exp_mem[i]);
    end
  endtask

  // t0 is the cycle whose closing edge samples start.
  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({busy, done, err, bus.tx_start, bus.rd_en} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, bus.tx_start, bus.rd_en});
    else n_pass++;
    n_checks++;
    if ({bus.tx_data, bus.rd_row, bus.rd_col, cell_idx} !== '0)
      $display("FAIL reset_data: got tx_data=%0h row=%0d col=%0d idx=%0d expected all 0",
               bus.tx_data, bus.rd_row, bus.rd_col, cell_idx);
    else n_pass++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_full_transfer;
    int t0; bit ok;
    epoch++;
    push_frame(N);
    pulse_start(t0);
    wait_idle(400, ok);
    tick(2);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL full_idle: got busy timeout expected idle"); else n_pass++;
    n_checks++;
    if (first_rd_cyc !== t0 + 1) $display("FAIL rd_latency: got cycle %0d expected %0d", first_rd_cyc, t0 + 1);
    else n_pass++;
    n_checks++;
    if (first_tx_cyc !== t0 + 3) $display("FAIL tx_latency: got cycle %0d expected %0d", first_tx_cyc, t0 + 3);
    else n_pass++;
    n_checks++;
    if (n_tx !== N || n_done !== 1 || n_err !== 0)
      $display("FAIL full_counts: got tx=%0d done=%0d err=%0d expected %0d/1/0", n_tx, n_done, n_err, N);
    else n_pass++;
    n_checks++;
    if (exp_addr.size() !== 0 || cell_idx !== IW'(N - 1))
      $display("FAIL full_end: got pending=%0d idx=%0d expected 0/%0d", exp_addr.size(), cell_idx, N - 1);
    else n_pass++;
  endtask

  task automatic test_busy_hold;
    int t0, rel; bit ok;
    force_busy = 1'b1;
    epoch++;
    push_frame(N);
    pulse_start(t0);
    tick(8);
    n_checks++;
    if (n_tx !== 0 || busy !== 1'b1) $display("FAIL hold_start: got tx=%0d busy=%b expected 0/1", n_tx, busy);
    else n_pass++;
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    rel = cyc;
    wait_idle(400, ok);
    tick(2);
    n_checks++;
    if (first_tx_cyc !== rel) $display("FAIL hold_release: got cycle %0d expected %0d", first_tx_cyc, rel);
    else n_pass++;
    n_checks++;
    if (ok !== 1'b1 || n_tx !== N || n_done !== 1)
      $display("FAIL hold_counts: got ok=%b tx=%0d done=%0d expected 1/%0d/1", ok, n_tx, n_done, N);
    else n_pass++;
  endtask

  task automatic test_ack_timeout;
    int t0; bit ok;
    tx_mute = 1'b1;
    epoch++;
    push_frame(1);
    pulse_start(t0);
    wait_idle(60, ok);
    tick(2);
    tx_mute = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || n_err !== 1 || n_done !== 0 || n_tx !== 1)
      $display("FAIL timeout_counts: got ok=%b err=%0d done=%0d tx=%0d expected 1/1/0/1", ok, n_err, n_done, n_tx);
    else n_pass++;
    n_checks++;
    if (err_cyc - first_tx_cyc !== ACK_TO + 1)
      $display("FAIL timeout_delay: got %0d expected %0d", err_cyc - first_tx_cyc, ACK_TO + 1);
    else n_pass++;
  endtask

  task automatic test_abort;
    int t0;
    epoch++;
    push_frame(3);
    pulse_start(t0);
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (n_tx >= 3) break;
    end
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    n_checks++;
    if ({busy, bus.rd_en, bus.tx_start} !== 3'b000)
      $display("FAIL abort_idle: got busy/rd_en/tx_start=%b expected 000", {busy, bus.rd_en, bus.tx_start});
    else n_pass++;
    tick(100);
    n_checks++;
    if (n_tx !== 3 || n_done !== 0 || exp_addr.size() !== 0)
      $display("FAIL abort_counts: got tx=%0d done=%0d pending=%0d expected 3/0/0", n_tx, n_done, exp_addr.size());
    else n_pass++;
  endtask

  task automatic test_host_write;
    int t0; bit ok;
    epoch++;
    push_frame(N);
    pulse_start(t0);
    tick(2);
    host_wr_req = 1'b1; wr_addr = N - 1; wr_val = 8'hEE;
    wait_idle(400, ok);
    host_wr_req = 1'b0;
    tick(2);
    n_checks++;
    if (ok !== 1'b1 || n_gnt_busy !== 0 || n_tx !== N)
      $display("FAIL wr_locked: got ok=%b gnt_cycles=%0d tx=%0d expected 1/0/%0d", ok, n_gnt_busy, n_tx, N);
    else n_pass++;
    tick(30);
    epoch++;
    exp_mem[0] = 8'hA5;
    push_frame(N);
    @(negedge clk);
    host_wr_req = 1'b1; wr_addr = 0; wr_val = 8'hA5; start = 1'b1;
    #1;
    n_checks++;
    if (host_wr_gnt !== 1'b1) $display("FAIL wr_idle_gnt: got %b expected 1", host_wr_gnt); else n_pass++;
    @(negedge clk);
    host_wr_req = 1'b0; start = 1'b0;
    wait_idle(400, ok);
    tick(2);
    n_checks++;
    if (ok !== 1'b1 || n_tx !== N || n_done !== 1)
      $display("FAIL wr_start_counts: got ok=%b tx=%0d done=%0d expected 1/%0d/1", ok, n_tx, n_done, N);
    else n_pass++;
  endtask

  task automatic test_reset_in_drain;
    int t0; bit ok;
    tick(30);
    epoch++;
    push_frame(1);
    pulse_start(t0);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (n_tx >= 1) break;
    end
    tick(5);
    n_checks++;
    if (busy !== 1'b1 || bus.tx_busy !== 1'b1)
      $display("FAIL drain_entry: got busy=%b tx_busy=%b expected 1/1", busy, bus.tx_busy);
    else n_pass++;
    rst = 1'b1;
    tick(1);
    n_checks++;
    if ({busy, done, err, bus.tx_start, bus.rd_en} !== 5'b0 ||
        {bus.tx_data, bus.rd_row, bus.rd_col, cell_idx} !== '0)
      $display("FAIL drain_reset: got ctrl=%b tx_data=%0h row=%0d col=%0d idx=%0d expected all 0",
               {busy, done, err, bus.tx_start, bus.rd_en}, bus.tx_data, bus.rd_row, bus.rd_col, cell_idx);
    else n_pass++;
    rst = 1'b0;
    tick(2);
    n_checks++;
    if (n_done !== 0) $display("FAIL drain_no_done: got %0d expected 0", n_done); else n_pass++;
    tick(30);
    epoch++;
    push_frame(N);
    pulse_start(t0);
    wait_idle(400, ok);
    tick(2);
    n_checks++;
    if (ok !== 1'b1 || n_tx !== N || n_done !== 1 || exp_addr.size() !== 0)
      $display("FAIL drain_restart: got ok=%b tx=%0d done=%0d pending=%0d expected 1/%0d/1/0",
               ok, n_tx, n_done, exp_addr.size(), N);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    for (int i = 0; i < N; i++) write_cell(i, W'(i + 1));
    tick(2);
    test_full_transfer;
    test_busy_hold;
    test_ack_timeout;
    test_abort;
    tick(30);
    test_host_write;
    test_reset_in_drain;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
